// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - soc_bus address map, STATUS layout and region enum
package soc_pkg;

  localparam logic [3:0] TXDATA_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam int         CH_STRIDE  = 16;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_UART,
    REG_NONE
  } region_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - 8-bit synchronous FIFO reporting its fill level
module sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          push_ok, pop_ok;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign push_ok = i_push && (count != LW'(DEPTH));
  assign pop_ok  = i_pop && (count != '0);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

  assign o_data  = mem[rd_ptr];
  assign o_level = count;

endmodule

// File: rtl/soc_bus.sv
// rtl/soc_bus.sv - CPU/RAM/UART bus fabric with boot loader; SOC_BUS_STATUS_EN adds STATUS registers
module soc_bus
  import soc_pkg::*;
#(
  parameter int          NUM_UART   = 2,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] UART_BASE  = 32'h8000_0000,
  parameter logic [31:0] LOAD_BASE  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_running,
  input  logic [31:0]           i_cpu_rd_addr,
  output logic [31:0]           o_cpu_rd_data,
  input  logic                  i_cpu_wr_valid,
  input  logic [31:0]           i_cpu_wr_addr,
  input  logic [31:0]           i_cpu_wr_data,
  output logic                  o_cpu_stall,
  output logic [31:0]           o_ram_rd_addr,
  input  logic [31:0]           i_ram_rd_data,
  output logic                  o_ram_wr_valid,
  output logic [31:0]           o_ram_wr_addr,
  output logic [31:0]           o_ram_wr_data,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic [NUM_UART-1:0]   o_tx_valid,
  output logic [8*NUM_UART-1:0] o_tx_data,
  input  logic [NUM_UART-1:0]   i_tx_ready
);

  localparam int             LW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]     NUM_CH   = 4'(NUM_UART);
  localparam logic [LW-1:0]  FULL_LVL = LW'(FIFO_DEPTH);

  // ---------------- write decode and TX FIFOs ----------------
  logic          wr_uart, wr_tx_hit, sel_full;
  logic [2:0]    wr_ch;
  logic [LW-1:0] level [NUM_UART];
  logic [NUM_UART-1:0] full, push;

  assign wr_uart   = (i_cpu_wr_addr[31:28] == UART_BASE[31:28]);
  assign wr_ch     = i_cpu_wr_addr[6:4];
  assign wr_tx_hit = wr_uart && (i_cpu_wr_addr[3:0] == TXDATA_OFS) && ({1'b0, wr_ch} < NUM_CH);

  always_comb begin
    sel_full = 1'b0;
    push     = '0;
    for (int k = 0; k < NUM_UART; k++) begin
      if (wr_ch == 3'(k)) begin
        sel_full = full[k];
        push[k]  = i_running && i_cpu_wr_valid && wr_tx_hit && !full[k];
      end
    end
  end

  assign o_cpu_stall = i_running && i_cpu_wr_valid && wr_tx_hit && sel_full;

  for (genvar k = 0; k < NUM_UART; k++) begin : g_tx
    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .i_reset (i_reset),
      .i_push  (push[k]),
      .i_data  (i_cpu_wr_data[7:0]),
      .i_pop   (o_tx_valid[k] && i_tx_ready[k]),
      .o_data  (o_tx_data[8*k +: 8]),
      .o_level (level[k])
    );
    assign full[k]       = (level[k] == FULL_LVL);
    assign o_tx_valid[k] = (level[k] != '0);
  end

  // ---------------- read path ----------------
  region_t     rd_region_d, rd_region_q;
  logic [31:0] status_word;

  always_comb begin
    rd_region_d = REG_RAM;
    if (i_cpu_rd_addr[31:28] == UART_BASE[31:28]) begin
      rd_region_d = REG_NONE;
`ifdef SOC_BUS_STATUS_EN
      if (i_cpu_rd_addr[3:0] == STATUS_OFS && {1'b0, i_cpu_rd_addr[6:4]} < NUM_CH)
        rd_region_d = REG_UART;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) rd_region_q <= REG_NONE;
    else         rd_region_q <= rd_region_d;
  end

`ifdef SOC_BUS_STATUS_EN
  logic [2:0] rd_ch_q;

  always_ff @(posedge clk) begin
    if (i_reset) rd_ch_q <= '0;
    else         rd_ch_q <= i_cpu_rd_addr[6:4];
  end

  always_comb begin
    status_word = '0;
    for (int k = 0; k < NUM_UART; k++) begin
      if (rd_ch_q == 3'(k)) begin
        status_word[STATUS_EMPTY_BIT]        = (level[k] == '0);
        status_word[STATUS_FULL_BIT]         = full[k];
        status_word[STATUS_LEVEL_LSB +: 8]   = 8'(level[k]);
      end
    end
  end
`else
  assign status_word = '0;
`endif

  always_comb begin
    o_cpu_rd_data = '0;
    case (rd_region_q)
      REG_RAM:  o_cpu_rd_data = i_ram_rd_data;
      REG_UART: o_cpu_rd_data = status_word;
      default:  o_cpu_rd_data = '0;
    endcase
  end

  // ---------------- boot loader ----------------
  logic [1:0]  byte_cnt;
  logic [23:0] partial;
  logic [31:0] load_ptr, ld_addr, ld_data;
  logic        ld_valid;

  // Run mode holds the byte count at zero, so a partial word never survives a mode change.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      byte_cnt <= '0;
      partial  <= '0;
      load_ptr <= LOAD_BASE;
      ld_valid <= 1'b0;
      ld_addr  <= '0;
      ld_data  <= '0;
    end else begin
      ld_valid <= 1'b0;
      if (i_running) begin
        byte_cnt <= '0;
      end else if (i_rx_valid) begin
        if (byte_cnt == 2'd3) begin
          ld_valid <= 1'b1;
          ld_addr  <= load_ptr;
          ld_data  <= {i_rx_data, partial};
          load_ptr <= load_ptr + 32'd4;
          byte_cnt <= '0;
        end else begin
          case (byte_cnt)
            2'd0:    partial[7:0]   <= i_rx_data;
            2'd1:    partial[15:8]  <= i_rx_data;
            default: partial[23:16] <= i_rx_data;
          endcase
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

  assign o_ram_rd_addr  = i_cpu_rd_addr;
  assign o_ram_wr_valid = i_running ? (i_cpu_wr_valid && !wr_uart) : ld_valid;
  assign o_ram_wr_addr  = i_running ? i_cpu_wr_addr : ld_addr;
  assign o_ram_wr_data  = i_running ? i_cpu_wr_data : ld_data;

endmodule

// File: tb/tb_soc_bus.sv
// tb/tb_soc_bus.sv - directed self-checking bench for soc_bus (NUM_UART=2, FIFO_DEPTH=4)
module tb_soc_bus;

  localparam logic [31:0] UB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        i_reset, i_running;
  logic [31:0] i_cpu_rd_addr, o_cpu_rd_data;
  logic        i_cpu_wr_valid;
  logic [31:0] i_cpu_wr_addr, i_cpu_wr_data;
  logic        o_cpu_stall;
  logic [31:0] o_ram_rd_addr, i_ram_rd_data;
  logic        o_ram_wr_valid;
  logic [31:0] o_ram_wr_addr, o_ram_wr_data;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic [1:0]  o_tx_valid, i_tx_ready;
  logic [15:0] o_tx_data;

  int checks = 0;
  int errors = 0;

  soc_bus #(.NUM_UART(2), .FIFO_DEPTH(4), .UART_BASE(UB), .LOAD_BASE(32'h0)) dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_running      (i_running),
    .i_cpu_rd_addr  (i_cpu_rd_addr),
    .o_cpu_rd_data  (o_cpu_rd_data),
    .i_cpu_wr_valid (i_cpu_wr_valid),
    .i_cpu_wr_addr  (i_cpu_wr_addr),
    .i_cpu_wr_data  (i_cpu_wr_data),
    .o_cpu_stall    (o_cpu_stall),
    .o_ram_rd_addr  (o_ram_rd_addr),
    .i_ram_rd_data  (i_ram_rd_data),
    .o_ram_wr_valid (o_ram_wr_valid),
    .o_ram_wr_addr  (o_ram_wr_addr),
    .o_ram_wr_data  (o_ram_wr_data),
    .i_rx_valid     (i_rx_valid),
    .i_rx_data      (i_rx_data),
    .o_tx_valid     (o_tx_valid),
    .o_tx_data      (o_tx_data),
    .i_tx_ready     (i_tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    step();
    i_rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  logic [7:0] pack_bytes [8];

  initial begin
    i_running = 1'b0; i_cpu_rd_addr = 32'h0; i_cpu_wr_valid = 1'b0;
    i_cpu_wr_addr = 32'h0; i_cpu_wr_data = 32'h0; i_ram_rd_data = 32'hCAFE_F00D;
    i_rx_valid = 1'b0; i_rx_data = 8'h0; i_tx_ready = 2'b00; i_reset = 1'b0;
    i_cpu_rd_addr = UB + 32'h70;
    do_reset();
    #1;
    check("reset_rd_data", o_cpu_rd_data, 32'h0);
    check("reset_ram_wr_valid", {31'b0, o_ram_wr_valid}, 32'h0);
    check("reset_tx_valid", {30'b0, o_tx_valid}, 32'h0);
    check("reset_stall", {31'b0, o_cpu_stall}, 32'h0);

    // loader packing, back-to-back bytes
    pack_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    i_rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_rx_data = pack_bytes[i];
      step();
      if (i == 3) begin
        check("pack0_valid", {31'b0, o_ram_wr_valid}, 32'h1);
        check("pack0_addr", o_ram_wr_addr, 32'h0);
        check("pack0_data", o_ram_wr_data, 32'h4433_2211);
      end else if (i == 4) begin
        check("pack_pulse_end", {31'b0, o_ram_wr_valid}, 32'h0);
      end else if (i == 7) begin
        check("pack1_valid", {31'b0, o_ram_wr_valid}, 32'h1);
        check("pack1_addr", o_ram_wr_addr, 32'h4);
        check("pack1_data", o_ram_wr_data, 32'h8877_6655);
      end
    end
    i_rx_valid = 1'b0;

    // partial word discarded by a run-mode excursion; reset restores P
    do_reset();
    rx_byte(8'h01);
    rx_byte(8'h02);
    i_running = 1'b1; step();
    i_running = 1'b0; step();
    rx_byte(8'hAA);
    rx_byte(8'hBB);
    rx_byte(8'hCC);
    check("discard_no_early_write", {31'b0, o_ram_wr_valid}, 32'h0);
    rx_byte(8'hDD);
    check("discard_valid", {31'b0, o_ram_wr_valid}, 32'h1);
    check("discard_addr", o_ram_wr_addr, 32'h0);
    check("discard_data", o_ram_wr_data, 32'hDDCC_BBAA);

    // run mode: RX ignored, RAM writes pass through
    i_running = 1'b1;
    rx_byte(8'h10); rx_byte(8'h20); rx_byte(8'h30); rx_byte(8'h40);
    check("run_rx_ignored", {31'b0, o_ram_wr_valid}, 32'h0);
    i_cpu_wr_valid = 1'b1; i_cpu_wr_addr = 32'h40; i_cpu_wr_data = 32'h1234_5678;
    #1;
    check("ram_pass_valid", {31'b0, o_ram_wr_valid}, 32'h1);
    check("ram_pass_addr", o_ram_wr_addr, 32'h40);
    check("ram_pass_data", o_ram_wr_data, 32'h1234_5678);
    check("ram_pass_stall", {31'b0, o_cpu_stall}, 32'h0);
    step();

    // fill channel 1 with ready held low
    i_cpu_wr_addr = UB + 32'h10;
    for (int i = 1; i <= 4; i++) begin
      i_cpu_wr_data = i;
      #1;
      check($sformatf("fill_stall_%0d", i), {31'b0, o_cpu_stall}, 32'h0);
      step();
      if (i == 1) check("ch1_valid_next", {30'b0, o_tx_valid}, 32'h2);
    end

    // channel 0 accepts while channel 1 is full
    i_cpu_wr_addr = UB; i_cpu_wr_data = 32'h5A;
    #1;
    check("ch0_no_stall", {31'b0, o_cpu_stall}, 32'h0);
    step();
    check("ch0_valid_next", {30'b0, o_tx_valid}, 32'h3);
    check("ch0_head", {24'b0, o_tx_data[7:0]}, 32'h5A);
    i_cpu_wr_data = 32'h5B; step();
    i_cpu_wr_data = 32'h5C; step();

    // fifth write to channel 1 stalls, including the cycle it is popped
    i_cpu_wr_addr = UB + 32'h10; i_cpu_wr_data = 32'h05;
    #1;
    check("full_stall", {31'b0, o_cpu_stall}, 32'h1);
    step();
    check("full_stall_held", {31'b0, o_cpu_stall}, 32'h1);
    check("ch1_head1", {24'b0, o_tx_data[15:8]}, 32'h01);
    i_tx_ready = 2'b10;
    #1;
    check("full_stall_with_pop", {31'b0, o_cpu_stall}, 32'h1);
    step();
    i_tx_ready = 2'b00;
    #1;
    check("stall_released", {31'b0, o_cpu_stall}, 32'h0);
    check("ch1_head2", {24'b0, o_tx_data[15:8]}, 32'h02);
    step();
    i_cpu_wr_valid = 1'b0;
    i_tx_ready = 2'b10;
    for (int j = 2; j <= 5; j++) begin
      check($sformatf("drain_%0d", j), {24'b0, o_tx_data[15:8]}, j);
      step();
    end
    i_tx_ready = 2'b00;
    check("ch1_drained", {30'b0, o_tx_valid}, 32'h1);

    // status and RAM reads
    i_cpu_rd_addr = UB + 32'h4; step();
`ifdef SOC_BUS_STATUS_EN
    check("status_ch0", o_cpu_rd_data, 32'h0000_0300);
`else
    check("status_ch0", o_cpu_rd_data, 32'h0);
`endif
    i_cpu_rd_addr = UB + 32'h14; step();
`ifdef SOC_BUS_STATUS_EN
    check("status_ch1", o_cpu_rd_data, 32'h0000_0001);
`else
    check("status_ch1", o_cpu_rd_data, 32'h0);
`endif
    i_cpu_rd_addr = UB + 32'h8; step();
    check("unmapped_read", o_cpu_rd_data, 32'h0);
    i_cpu_rd_addr = 32'h100; step();
    check("ram_read", o_cpu_rd_data, 32'hCAFE_F00D);
    check("ram_rd_addr", o_ram_rd_addr, 32'h100);

    // unmapped writes dropped without stall
    i_cpu_wr_valid = 1'b1; i_cpu_wr_addr = UB + 32'h70; i_cpu_wr_data = 32'h99;
    #1;
    check("unmapped_ch_stall", {31'b0, o_cpu_stall}, 32'h0);
    check("unmapped_no_ram", {31'b0, o_ram_wr_valid}, 32'h0);
    step();
    i_cpu_wr_addr = UB + 32'h18;
    step();
    i_cpu_wr_valid = 1'b0;
    check("unmapped_dropped", {30'b0, o_tx_valid}, 32'h1);

    // reset mid-stream drops FIFO contents, partial word and P
    i_running = 1'b0;
    rx_byte(8'hE1);
    rx_byte(8'hE2);
    i_cpu_rd_addr = UB + 32'h4;
    i_reset = 1'b1; step(); i_reset = 1'b0;
    check("rst_tx_valid", {30'b0, o_tx_valid}, 32'h0);
    check("rst_rd_data", o_cpu_rd_data, 32'h0);
    check("rst_stall", {31'b0, o_cpu_stall}, 32'h0);
    check("rst_ram_wr_valid", {31'b0, o_ram_wr_valid}, 32'h0);
    rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03); rx_byte(8'h04);
    check("rst_load_valid", {31'b0, o_ram_wr_valid}, 32'h1);
    check("rst_load_addr", o_ram_wr_addr, 32'h0);
    check("rst_load_data", o_ram_wr_data, 32'h0403_0201);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
